// File: rtl/imem_load_fetch_ctrl_if.sv
// Bundle of loader stream, CPU fetch port and instruction-RAM port for the imem controller.
// No logic inside; master is the surrounding system (host loader, core, RAM), slave is the controller.
// Loader flow control is ld_valid/ld_ready; the fetch and RAM sides have no backpressure.
interface imem_load_fetch_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              ld_start;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_end;
    logic              ld_ready;

    logic              cpu_req;
    logic [15:0]       cpu_pc;
    logic [DATA_W-1:0] cpu_instr;
    logic              cpu_valid;
    logic              cpu_hold;
    logic              fetch_fault;
    logic [ADDR_W:0]   words_loaded;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output ld_start, ld_valid, ld_data, ld_end, cpu_req, cpu_pc, mem_rdata,
        input  ld_ready, cpu_instr, cpu_valid, cpu_hold, fetch_fault, words_loaded,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_end, cpu_req, cpu_pc, mem_rdata,
        output ld_ready, cpu_instr, cpu_valid, cpu_hold, fetch_fault, words_loaded,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_load_fetch_ctrl.sv
// Loads the instruction RAM from a byte stream, then serves CPU fetches from it.
// Latency: RAM write in the low-byte handshake cycle; fetch data one cycle after cpu_req.
// Backpressure: ld_ready only while loading; core held via cpu_hold until the load finishes.
module imem_load_fetch_ctrl #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input logic                   clk,
    input logic                   rst_n,
    imem_load_fetch_ctrl_if.slave bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]        state;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   wr_cnt;
    logic              cpu_valid_q;
    logic              oor_q;
    logic              fault_q;
    logic [DATA_W-1:0] instr_hold;

    logic              in_load;
    logic              in_run;
    logic              byte_hs;
    logic              wr_fire;
    logic              pc_oor;
    logic              fetch;
    logic [DATA_W-1:0] cpu_instr_w;
    logic              unused_pc_lsb;

    assign in_load = (state == LOAD);
    assign in_run  = (state == RUN);

    // A restart pulse wins over any byte offered in the same cycle.
    assign byte_hs = in_load & bus.ld_valid & ~bus.ld_start;
    assign wr_fire = byte_hs & phase;

    // Upper PC bits beyond the RAM's byte range mark an out-of-range fetch.
    assign pc_oor        = |bus.cpu_pc[15:ADDR_W+1];
    assign fetch         = in_run & bus.cpu_req & ~bus.ld_start;
    assign unused_pc_lsb = bus.cpu_pc[0];

    assign bus.ld_ready     = in_load;
    assign bus.cpu_hold     = ~in_run;
    assign bus.mem_we       = wr_fire;
    assign bus.mem_wdata    = wr_fire ? {hi_byte, bus.ld_data} : '0;
    assign bus.mem_addr     = (in_run & bus.cpu_req) ? bus.cpu_pc[ADDR_W:1] :
                              (in_load ? wr_cnt[ADDR_W-1:0] : '0);
    assign bus.words_loaded = wr_cnt;
    assign bus.fetch_fault  = fault_q;
    assign bus.cpu_valid    = cpu_valid_q;

    // RAM data is only valid in the cycle after the address, so pass it through then and hold it otherwise.
    assign cpu_instr_w   = cpu_valid_q ? (oor_q ? NOP_WORD : bus.mem_rdata) : instr_hold;
    assign bus.cpu_instr = cpu_instr_w;

    // Load sequencing: state, byte phase, high-byte latch and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HALT;
            phase   <= 1'b0;
            hi_byte <= '0;
            wr_cnt  <= '0;
        end else if (bus.ld_start) begin
            state  <= LOAD;
            phase  <= 1'b0;
            wr_cnt <= '0;
        end else if (in_load) begin
            if (byte_hs) begin
                if (!phase) begin
                    hi_byte <= bus.ld_data;
                    phase   <= 1'b1;
                end else begin
                    phase  <= 1'b0;
                    wr_cnt <= wr_cnt + 1'b1;
                    if (wr_cnt == LAST_WORD) begin
                        state <= RUN;
                    end
                end
            end
            // Early end drops a half-received word; a word completed this cycle is already written.
            if (bus.ld_end) begin
                state <= RUN;
                phase <= 1'b0;
            end
        end
    end

    // Fetch pipeline: valid/out-of-range tracking, sticky fault and held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_valid_q <= 1'b0;
            oor_q       <= 1'b0;
            fault_q     <= 1'b0;
            instr_hold  <= '0;
        end else begin
            cpu_valid_q <= fetch;
            if (fetch) begin
                oor_q <= pc_oor;
            end
            if (bus.ld_start) begin
                fault_q <= 1'b0;
            end else if (fetch && pc_oor) begin
                fault_q <= 1'b1;
            end
            if (cpu_valid_q) begin
                instr_hold <= cpu_instr_w;
            end
        end
    end
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Self-checking bench for imem_load_fetch_ctrl with a behavioural RAM and reference model.
module tb_imem_load_fetch_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    imem_load_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_load_fetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read RAM, one-cycle read latency.
    logic [15:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Reference view: what the RAM should hold, last delivered instruction, fault flag.
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_last;
    int          ref_words;
    bit          ref_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_end   = 1'b0;
        bus.cpu_req  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hold"},  bus.cpu_hold, 1);
        check({tag, "_ready"}, bus.ld_ready, 0);
        check({tag, "_valid"}, bus.cpu_valid, 0);
        check({tag, "_instr"}, bus.cpu_instr, 0);
        check({tag, "_fault"}, bus.fetch_fault, 0);
        check({tag, "_words"}, bus.words_loaded, 0);
        check({tag, "_we"},    bus.mem_we, 0);
        check({tag, "_addr"},  bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    // One RUN cycle: issue (or not) a fetch, then check the result of that cycle's request.
    task automatic fetch_cycle(input bit req, input logic [15:0] pc);
        bit oor;
        oor = (pc[15:ADDR_W+1] != 0);
        bus.cpu_req = req;
        bus.cpu_pc  = pc;
        #1;
        if (req && !oor) check("fetch_addr", bus.mem_addr, pc[ADDR_W:1]);
        tick();
        if (req) begin
            ref_last = oor ? 16'h0000 : ref_mem[pc[ADDR_W:1]];
            if (oor) ref_fault = 1'b1;
        end
        check("cpu_valid", bus.cpu_valid, req);
        check("cpu_instr", bus.cpu_instr, ref_last);
        check("fetch_fault", bus.fetch_fault, ref_fault);
    endtask

    task automatic fetch_all();
        for (int i = 0; i < DEPTH; i++) begin
            logic [15:0] pc;
            pc = {11'b0, 4'(i), 1'($urandom)};
            fetch_cycle(1'b1, pc);
        end
        fetch_cycle(1'b0, 16'h0000);
    endtask

    // Start a load and stream nbytes (high byte first), optionally restarting or ending early.
    task automatic load(input int nbytes, input bit end_with_last, input bit seq_data,
                        input int restart_after, input bit with_req);
        logic [15:0] wv [DEPTH];
        int k;
        int cyc;
        bit restarted;
        bit v;
        for (int i = 0; i < DEPTH; i++) wv[i] = seq_data ? 16'(16'h1000 + i) : 16'($urandom);
        bus.ld_start = 1'b1;
        bus.cpu_req  = with_req;
        bus.cpu_pc   = 16'h0000;
        tick();
        bus.ld_start = 1'b0;
        bus.cpu_req  = 1'b0;
        ref_words = 0;
        ref_fault = 1'b0;
        check("start_valid", bus.cpu_valid, 0);
        check("start_hold",  bus.cpu_hold, 1);
        check("start_ready", bus.ld_ready, 1);
        check("start_fault", bus.fetch_fault, 0);
        check("start_words", bus.words_loaded, 0);
        k = 0;
        cyc = 0;
        restarted = 1'b0;
        while (k < nbytes && cyc < 1000) begin
            cyc++;
            if (!restarted && k == restart_after) begin
                bus.ld_start = 1'b1;
                bus.ld_valid = 1'($urandom);
                bus.ld_data  = 8'($urandom);
                #1;
                check("restart_we", bus.mem_we, 0);
                tick();
                bus.ld_start = 1'b0;
                restarted = 1'b1;
                k = 0;
                check("restart_words", bus.words_loaded, 0);
                continue;
            end
            v = ($urandom_range(0, 3) != 0);
            bus.ld_valid = v;
            if (!v) bus.ld_data = 8'($urandom);
            else if (k % 2 == 0) bus.ld_data = wv[k/2][15:8];
            else bus.ld_data = wv[k/2][7:0];
            bus.ld_end = v && end_with_last && (k == nbytes - 1);
            #1;
            check("ld_ready", bus.ld_ready, 1);
            check("ld_we", bus.mem_we, v && (k % 2 == 1));
            if (v && (k % 2 == 1)) begin
                check("ld_addr", bus.mem_addr, k / 2);
                check("ld_wdata", bus.mem_wdata, wv[k/2]);
                ref_mem[k/2] = wv[k/2];
            end
            tick();
            if (v) k++;
        end
        check("ld_budget", k, nbytes);
        bus.ld_valid = 1'b0;
        bus.ld_end   = 1'b0;
        if (nbytes < 2 * DEPTH && !end_with_last) begin
            bus.ld_end = 1'b1;
            #1;
            check("end_we", bus.mem_we, 0);
            tick();
            bus.ld_end = 1'b0;
        end
        ref_words = nbytes / 2;
        check("ld_words", bus.words_loaded, ref_words);
        check("ld_run_hold", bus.cpu_hold, 0);
        check("ld_run_ready", bus.ld_ready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        idle();
        bus.cpu_pc  = 16'h0000;
        bus.ld_data = 8'h00;
        ref_words = 0;
        ref_fault = 1'b0;
        ref_last  = 16'h0000;
        #2 rst_n = 1'b0;
        #10;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // HALT ignores both fetches and loader bytes.
        for (int i = 0; i < 3; i++) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_pc   = 16'(2 * i);
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'($urandom);
            #1;
            check("halt_we", bus.mem_we, 0);
            tick();
            check("halt_valid", bus.cpu_valid, 0);
            check("halt_hold", bus.cpu_hold, 1);
            check("halt_ready", bus.ld_ready, 0);
        end
        idle();

        // Full load of 16'h1000+i, then back-to-back fetch of every word.
        load(2 * DEPTH, 1'b0, 1'b1, -1, 1'b0);
        for (int i = 0; i < DEPTH; i++) fetch_cycle(1'b1, 16'(2 * i));
        fetch_cycle(1'b0, 16'h0000);

        // Out-of-range fetch returns NOP and raises a sticky fault.
        fetch_cycle(1'b1, 16'h0040);
        for (int i = 0; i < 3; i++) fetch_cycle(1'b0, 16'h0000);

        // Random fetch mix, including occasional out-of-range addresses.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
            fetch_cycle($urandom_range(0, 3) != 0, pc);
        end
        fetch_cycle(1'b0, 16'h0000);

        // ld_start with a simultaneous fetch, 5 bytes then ld_end: two words overwrite from 0.
        load(5, 1'b0, 1'b0, -1, 1'b1);
        fetch_all();

        // Random partial loads with random early-end placement and mid-load restarts.
        for (int it = 0; it < 5; it++) begin
            int n;
            int rs;
            n  = $urandom_range(1, 2 * DEPTH - 1);
            rs = ($urandom_range(0, 1) == 1 && n > 1) ? $urandom_range(1, n - 1) : -1;
            load(n, 1'($urandom), 1'b0, rs, 1'($urandom));
            fetch_all();
        end

        // Reset in the middle of a load: outputs return to reset values asynchronously.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'($urandom);
            tick();
        end
        check("pre_rst_words", bus.words_loaded, 3);
        bus.ld_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        ref_last = 16'h0000;
        check_reset_values("arst");
        tick();
        check("arst_we_hold", bus.mem_we, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.cpu_req  = 1'b1;
            bus.cpu_pc   = 16'(2 * i);
            #1;
            check("post_rst_we", bus.mem_we, 0);
            tick();
            check("post_rst_valid", bus.cpu_valid, 0);
            check("post_rst_hold", bus.cpu_hold, 1);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_load_fetch_ctrl.md
Name: imem_load_fetch_ctrl

Overview:
Controller for the 16-bit RISC core's writable instruction memory. It sequences a byte-stream program loader that fills the memory, then hands the memory to the CPU fetch path, holding the core in stall until the load completes. It sits between the core's PC/instruction interface, a host loader stream, and a single-port synchronous-read instruction RAM. The RAM has one-cycle read latency and a 16 x 16-bit default geometry.

Parameters:
ADDR_W, 4, word-address width; DEPTH = 2**ADDR_W words
DATA_W, 16, instruction width; fixed at 2 bytes per word
NOP_WORD, 16'h0000, instruction returned for out-of-range fetches

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_start  in  1  one-cycle pulse: begin a (re)load at word 0
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte; high byte first, then low byte
ld_end  in  1  pulse: terminate the load early
ld_ready  out  1  controller accepts a loader byte
cpu_req  in  1  fetch request for cpu_pc
cpu_pc  in  16  byte address; word index = cpu_pc[ADDR_W:1]
cpu_instr  out  DATA_W  fetched instruction
cpu_valid  out  1  cpu_instr valid this cycle
cpu_hold  out  1  core must stall
fetch_fault  out  1  sticky flag: out-of-range fetch seen
words_loaded  out  ADDR_W+1  number of words written by the last load
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Reset, asynchronous: state=HALT; cpu_hold=1; ld_ready=0; cpu_valid=0; cpu_instr=0; fetch_fault=0; words_loaded=0; mem_we=0; mem_addr=0; mem_wdata=0; byte phase=0; write counter=0.
- States: HALT, LOAD, RUN. Outputs are registered unless noted. ld_ready=1 exactly while in LOAD (decoded from state). cpu_hold=1 in HALT and LOAD.
- HALT or RUN, ld_start=1 -> LOAD next cycle. Write counter=0, phase=0, words_loaded=0, fetch_fault cleared. An in-flight cpu_valid is suppressed. ld_start has priority over a simultaneous cpu_req.
- ld_start while already in LOAD restarts the load: counter=0, phase=0, any pending high byte dropped.
- LOAD, on a byte handshake (ld_valid & ld_ready):
  - phase 0: latch byte as the high byte; phase becomes 1.
  - phase 1: drive mem_we=1 for one cycle with mem_addr=counter and mem_wdata={high,low}. Counter and words_loaded increment; phase becomes 0.
- LOAD completes when the DEPTH-th word is written. State becomes RUN the cycle after that write; words_loaded=DEPTH; ld_ready drops in the same cycle.
- ld_end in LOAD -> RUN next cycle.
  - A pending high byte (phase 1) is discarded and not written.
  - ld_end coincident with a low-byte handshake: the word is written first, then RUN.
- RUN, cpu_req=1:
  - mem_addr=cpu_pc[ADDR_W:1] in the same cycle (combinational address path).
  - Next cycle: cpu_valid=1 and cpu_instr=mem_rdata (1-cycle latency, back-to-back fetches allowed).
  - cpu_req=0: cpu_valid=0 next cycle; cpu_instr holds its last value.
- Out-of-range fetch: a RUN fetch with cpu_pc[15:ADDR_W+1]!=0 returns cpu_instr=NOP_WORD with cpu_valid=1 at the same latency, and sets fetch_fault until the next ld_start or reset.
- Word index at or above words_loaded (but within DEPTH) is not a fault; the RAM contents are returned as-is.
- mem_we is never asserted outside LOAD. cpu_req is ignored in HALT and LOAD (cpu_valid stays 0).
- Reset mid-load: immediate return to HALT; the partial RAM contents are unspecified but no further writes occur.

Test Plan:
- Reset, then a full load of 32 bytes encoding words 16'h1000+i -> 16 writes at addr 0..15; words_loaded=16; RUN one cycle after the last write; cpu_hold=0.
- After load, cpu_req with pc=0,2,4,...,30 back-to-back -> cpu_valid every cycle from cycle 2; cpu_instr=16'h1000..16'h100F in order.
- Partial load: 5 bytes, then ld_end -> 2 words written; the 5th byte is discarded; words_loaded=2; state RUN.
- Fetch with pc=16'h0040 in RUN -> cpu_instr=16'h0000 and cpu_valid=1 the next cycle; fetch_fault=1 and sticky until ld_start.
- ld_start and cpu_req in the same RUN cycle -> no cpu_valid; cpu_hold=1 next cycle; ld_ready=1; a subsequent load overwrites from addr 0.
- rst_n asserted after 3 of 16 words written -> all outputs at reset values asynchronously; no mem_we after reset; cpu_hold=1.
